cdb_wakeup_rs: RTL and testbench

//  ALU reservation station and the receiving end of the two-lane common data bus.
//  - Buffers dispatched ALU ops.
//  - Snoops cdb1 (load/store buffer) and cdb2 (ALU) to wake pending operands.
//  - Issues one ready op per cycle, lowest index first, to the ALU.

---
 rtl/cdb_wakeup_rs_if.sv | 51 +++++
 rtl/cdb_wakeup_rs.sv | 164 ++++++++++++++++
 tb/tb_cdb_wakeup_rs.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_wakeup_rs_if.sv
// Dispatch / CDB / issue bundle of the ALU reservation station.
// master = dispatch+CDB source and ALU sink, slave = reservation station.
interface cdb_wakeup_rs_if #(
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 6
);
  logic              rdy;
  logic              clear_i;
  logic              dispEn_i;
  logic [OP_W-1:0]   dispOp_i;
  logic [ROB_W-1:0]  dispRobId_i;
  logic [DATA_W-1:0] dispVj_i;
  logic              dispQjEn_i;
  logic [ROB_W-1:0]  dispQj_i;
  logic [DATA_W-1:0] dispVk_i;
  logic              dispQkEn_i;
  logic [ROB_W-1:0]  dispQk_i;
  logic [DATA_W-1:0] dispImm_i;
  logic [DATA_W-1:0] dispPc_i;
  logic              cdb1En_i;
  logic [ROB_W-1:0]  cdb1Id_i;
  logic [DATA_W-1:0] cdb1Data_i;
  logic              cdb2En_i;
  logic [ROB_W-1:0]  cdb2Id_i;
  logic [DATA_W-1:0] cdb2Data_i;
  logic              full_o;
  logic              aluEn_o;
  logic [OP_W-1:0]   aluOp_o;
  logic [DATA_W-1:0] aluA_o;
  logic [DATA_W-1:0] aluB_o;
  logic [DATA_W-1:0] aluImm_o;
  logic [DATA_W-1:0] aluPc_o;
  logic [ROB_W-1:0]  aluRobId_o;

  modport master (
    output rdy, clear_i,
    output dispEn_i, dispOp_i, dispRobId_i, dispVj_i, dispQjEn_i, dispQj_i,
    output dispVk_i, dispQkEn_i, dispQk_i, dispImm_i, dispPc_i,
    output cdb1En_i, cdb1Id_i, cdb1Data_i, cdb2En_i, cdb2Id_i, cdb2Data_i,
    input  full_o, aluEn_o, aluOp_o, aluA_o, aluB_o, aluImm_o, aluPc_o, aluRobId_o
  );

  modport slave (
    input  rdy, clear_i,
    input  dispEn_i, dispOp_i, dispRobId_i, dispVj_i, dispQjEn_i, dispQj_i,
    input  dispVk_i, dispQkEn_i, dispQk_i, dispImm_i, dispPc_i,
    input  cdb1En_i, cdb1Id_i, cdb1Data_i, cdb2En_i, cdb2Id_i, cdb2Data_i,
    output full_o, aluEn_o, aluOp_o, aluA_o, aluB_o, aluImm_o, aluPc_o, aluRobId_o
  );
endinterface

// File: rtl/cdb_wakeup_rs.sv
// ALU reservation station: buffers dispatched ops, wakes operands from two CDB lanes,
// issues the lowest-index ready entry each cycle. Option macro: CDB_BYPASS_EN.
module cdb_wakeup_rs #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  cdb_wakeup_rs_if.slave  rs
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ROB_W-1:0]  rob;
    logic              qj_en;
    logic [ROB_W-1:0]  qj;
    logic [DATA_W-1:0] vj;
    logic              qk_en;
    logic [ROB_W-1:0]  qk;
    logic [DATA_W-1:0] vk;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
  } rs_entry_t;

  rs_entry_t         ent_q [DEPTH];
  rs_entry_t         ent_w [DEPTH];
  rs_entry_t         disp_w;
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_nxt;
  logic [DEPTH-1:0]  ready_vec;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  free_idx;
  logic              full;
  logic              disp_we;

  logic              alu_en_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [DATA_W-1:0] alu_imm_q;
  logic [DATA_W-1:0] alu_pc_q;
  logic [ROB_W-1:0]  alu_rob_q;

  // Resolve one operand against both lanes; returns {still_pending, value}, cdb1 first.
  function automatic logic [DATA_W:0] wake_opnd(input logic             pend,
                                                input logic [ROB_W-1:0]  tag,
                                                input logic [DATA_W-1:0] val);
    logic [DATA_W:0] res;
    res = {pend, val};
    if (pend) begin
      if (rs.cdb1En_i && (rs.cdb1Id_i == tag))      res = {1'b0, rs.cdb1Data_i};
      else if (rs.cdb2En_i && (rs.cdb2Id_i == tag)) res = {1'b0, rs.cdb2Data_i};
    end
    return res;
  endfunction

  // Entries as they look after this cycle's broadcasts
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_w[i] = ent_q[i];
      {ent_w[i].qj_en, ent_w[i].vj} = wake_opnd(ent_q[i].qj_en, ent_q[i].qj, ent_q[i].vj);
      {ent_w[i].qk_en, ent_w[i].vk} = wake_opnd(ent_q[i].qk_en, ent_q[i].qk, ent_q[i].vk);
    end
  end

  // Incoming dispatch, with same-cycle broadcast forwarding
  always_comb begin
    disp_w.op  = rs.dispOp_i;
    disp_w.rob = rs.dispRobId_i;
    disp_w.qj  = rs.dispQj_i;
    disp_w.qk  = rs.dispQk_i;
    disp_w.imm = rs.dispImm_i;
    disp_w.pc  = rs.dispPc_i;
    {disp_w.qj_en, disp_w.vj} = wake_opnd(rs.dispQjEn_i, rs.dispQj_i, rs.dispVj_i);
    {disp_w.qk_en, disp_w.vk} = wake_opnd(rs.dispQkEn_i, rs.dispQk_i, rs.dispVk_i);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef CDB_BYPASS_EN
      ready_vec[i] = valid_q[i] & ~ent_w[i].qj_en & ~ent_w[i].qk_en;
`else
      ready_vec[i] = valid_q[i] & ~ent_q[i].qj_en & ~ent_q[i].qk_en;
`endif
    end
  end

  // Lowest-index ready entry and lowest-index free slot
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign full    = &valid_q;
  assign disp_we = rs.dispEn_i & ~full;

  always_comb begin
    valid_nxt = valid_q;
    if (sel_found) valid_nxt[sel_idx]  = 1'b0;
    if (disp_we)   valid_nxt[free_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      alu_en_q  <= 1'b0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_imm_q <= '0;
      alu_pc_q  <= '0;
      alu_rob_q <= '0;
    end else if (rs.clear_i) begin
      valid_q  <= '0;
      alu_en_q <= 1'b0;
    end else if (rs.rdy) begin
      valid_q  <= valid_nxt;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_w[i];
      if (disp_we) ent_q[free_idx] <= disp_w;
      alu_en_q <= sel_found;
      if (sel_found) begin
`ifdef CDB_BYPASS_EN
        alu_op_q  <= ent_w[sel_idx].op;
        alu_a_q   <= ent_w[sel_idx].vj;
        alu_b_q   <= ent_w[sel_idx].vk;
        alu_imm_q <= ent_w[sel_idx].imm;
        alu_pc_q  <= ent_w[sel_idx].pc;
        alu_rob_q <= ent_w[sel_idx].rob;
`else
        alu_op_q  <= ent_q[sel_idx].op;
        alu_a_q   <= ent_q[sel_idx].vj;
        alu_b_q   <= ent_q[sel_idx].vk;
        alu_imm_q <= ent_q[sel_idx].imm;
        alu_pc_q  <= ent_q[sel_idx].pc;
        alu_rob_q <= ent_q[sel_idx].rob;
`endif
      end
    end
  end

  assign rs.full_o     = full;
  assign rs.aluEn_o    = alu_en_q;
  assign rs.aluOp_o    = alu_op_q;
  assign rs.aluA_o     = alu_a_q;
  assign rs.aluB_o     = alu_b_q;
  assign rs.aluImm_o   = alu_imm_q;
  assign rs.aluPc_o    = alu_pc_q;
  assign rs.aluRobId_o = alu_rob_q;

endmodule

// File: tb/tb_cdb_wakeup_rs.sv
// Bench for cdb_wakeup_rs: directed scenarios plus random traffic against an
// entry-list reference model.
module tb_cdb_wakeup_rs;

  logic clk;
  logic rst_n;

  cdb_wakeup_rs_if #(.ROB_W(4), .DATA_W(32), .OP_W(6)) bus ();

  cdb_wakeup_rs #(.DEPTH(8), .ROB_W(4), .DATA_W(32), .OP_W(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rs   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [5:0]  op;
    logic [3:0]  rob;
    bit          jp;
    logic [3:0]  qj;
    logic [31:0] vj;
    bit          kp;
    logic [3:0]  qk;
    logic [31:0] vk;
    logic [31:0] imm;
    logic [31:0] pc;
  } ment_t;

  ment_t       mdl [8];
  bit          e_en;
  logic [5:0]  e_op;
  logic [31:0] e_a, e_b, e_imm, e_pc;
  logic [3:0]  e_rob;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) mdl[i].v = 1'b0;
    e_en = 1'b0; e_op = '0; e_a = '0; e_b = '0; e_imm = '0; e_pc = '0; e_rob = '0;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < 8; i++) if (!mdl[i].v) return 1'b0;
    return 1'b1;
  endfunction

  // A pending operand takes the first lane carrying its tag
  function automatic void wk(inout bit p, input logic [3:0] q, inout logic [31:0] v);
    if (!p) return;
    if (bus.cdb1En_i && bus.cdb1Id_i == q) begin v = bus.cdb1Data_i; p = 1'b0; end
    else if (bus.cdb2En_i && bus.cdb2Id_i == q) begin v = bus.cdb2Data_i; p = 1'b0; end
  endfunction

  // Advance the model across one clock edge using the inputs currently on the bus
  task automatic model_step();
    ment_t w [8];
    ment_t src;
    ment_t nd;
    int    pick;
    int    slot;
    bit    ok;
    bit    was_full;
    if (bus.clear_i) begin
      for (int i = 0; i < 8; i++) mdl[i].v = 1'b0;
      e_en = 1'b0;
      return;
    end
    if (!bus.rdy) return;
    was_full = model_full();
    for (int i = 0; i < 8; i++) begin
      w[i] = mdl[i];
      wk(w[i].jp, w[i].qj, w[i].vj);
      wk(w[i].kp, w[i].qk, w[i].vk);
    end
    pick = -1;
    for (int i = 0; i < 8; i++) begin
`ifdef CDB_BYPASS_EN
      ok = w[i].v && !w[i].jp && !w[i].kp;
`else
      ok = mdl[i].v && !mdl[i].jp && !mdl[i].kp;
`endif
      if (ok && pick < 0) pick = i;
    end
    if (pick >= 0) begin
`ifdef CDB_BYPASS_EN
      src = w[pick];
`else
      src = mdl[pick];
`endif
      e_en = 1'b1; e_op = src.op; e_a = src.vj; e_b = src.vk;
      e_imm = src.imm; e_pc = src.pc; e_rob = src.rob;
      w[pick].v = 1'b0;
    end else begin
      e_en = 1'b0;
    end
    if (bus.dispEn_i && !was_full) begin
      slot = -1;
      for (int i = 0; i < 8; i++) if (!mdl[i].v && slot < 0) slot = i;
      nd.v = 1'b1; nd.op = bus.dispOp_i; nd.rob = bus.dispRobId_i;
      nd.jp = bus.dispQjEn_i; nd.qj = bus.dispQj_i; nd.vj = bus.dispVj_i;
      nd.kp = bus.dispQkEn_i; nd.qk = bus.dispQk_i; nd.vk = bus.dispVk_i;
      nd.imm = bus.dispImm_i; nd.pc = bus.dispPc_i;
      wk(nd.jp, nd.qj, nd.vj);
      wk(nd.kp, nd.qk, nd.vk);
      w[slot] = nd;
    end
    for (int i = 0; i < 8; i++) mdl[i] = w[i];
  endtask

  task automatic idle();
    bus.rdy = 1'b1; bus.clear_i = 1'b0; bus.dispEn_i = 1'b0;
    bus.dispOp_i = '0; bus.dispRobId_i = '0;
    bus.dispVj_i = '0; bus.dispQjEn_i = 1'b0; bus.dispQj_i = '0;
    bus.dispVk_i = '0; bus.dispQkEn_i = 1'b0; bus.dispQk_i = '0;
    bus.dispImm_i = '0; bus.dispPc_i = '0;
    bus.cdb1En_i = 1'b0; bus.cdb1Id_i = '0; bus.cdb1Data_i = '0;
    bus.cdb2En_i = 1'b0; bus.cdb2Id_i = '0; bus.cdb2Data_i = '0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [3:0] rob,
                      input bit qjen, input logic [3:0] qj, input logic [31:0] vj,
                      input bit qken, input logic [3:0] qk, input logic [31:0] vk);
    bus.dispEn_i = 1'b1; bus.dispOp_i = op; bus.dispRobId_i = rob;
    bus.dispQjEn_i = qjen; bus.dispQj_i = qj; bus.dispVj_i = vj;
    bus.dispQkEn_i = qken; bus.dispQk_i = qk; bus.dispVk_i = vk;
    bus.dispImm_i = 32'h100 + 32'(rob);
    bus.dispPc_i  = 32'h4000 + 32'(rob) * 32'd4;
  endtask

  // One clock with the current inputs, then compare every output to the model
  task automatic cyc();
    chk("full", 64'(bus.full_o), 64'(model_full()));
    model_step();
    @(posedge clk);
    #1;
    chk("en",  64'(bus.aluEn_o),    64'(e_en));
    chk("op",  64'(bus.aluOp_o),    64'(e_op));
    chk("a",   64'(bus.aluA_o),     64'(e_a));
    chk("b",   64'(bus.aluB_o),     64'(e_b));
    chk("imm", 64'(bus.aluImm_o),   64'(e_imm));
    chk("pc",  64'(bus.aluPc_o),    64'(e_pc));
    chk("rob", 64'(bus.aluRobId_o), 64'(e_rob));
  endtask

  // Apply the broadcast already on the bus and step to the expected issue edge
  task automatic wake_cyc(input string tag);
    cyc();
`ifndef CDB_BYPASS_EN
    chk({tag, "_early"}, 64'(bus.aluEn_o), 64'(0));
    idle();
    cyc();
`endif
    chk({tag, "_en"}, 64'(bus.aluEn_o), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en",   64'(bus.aluEn_o), 64'(0));
    chk("rst_full", 64'(bus.full_o),  64'(0));
    chk("rst_a",    64'(bus.aluA_o),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // T2: ready dispatch issues after the next edge
    disp(6'd3, 4'd2, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
    cyc();
    chk("t2_lat", 64'(bus.aluEn_o), 64'(0));
    idle(); cyc();
    chk("t2_en",  64'(bus.aluEn_o),    64'(1));
    chk("t2_a",   64'(bus.aluA_o),     64'(5));
    chk("t2_b",   64'(bus.aluB_o),     64'(7));
    chk("t2_op",  64'(bus.aluOp_o),    64'(3));
    chk("t2_rob", 64'(bus.aluRobId_o), 64'(2));
    idle(); cyc();
    chk("t2_once", 64'(bus.aluEn_o), 64'(0));

    // T3: wakeup from lane 2
    disp(6'd9, 4'd5, 1'b1, 4'd4, 32'hDEAD, 1'b0, 4'd0, 32'd1);
    cyc();
    idle();
    repeat (2) begin
      cyc();
      chk("t3_wait", 64'(bus.aluEn_o), 64'(0));
    end
    bus.cdb2En_i = 1'b1; bus.cdb2Id_i = 4'd4; bus.cdb2Data_i = 32'h55;
    wake_cyc("t3");
    chk("t3_a", 64'(bus.aluA_o), 64'h55);
    idle(); cyc();

    // T4: both lanes wake different operands, then both lanes carry the same tag
    disp(6'd10, 4'd6, 1'b1, 4'd1, 32'd0, 1'b1, 4'd9, 32'd0);
    cyc(); idle();
    bus.cdb1En_i = 1'b1; bus.cdb1Id_i = 4'd1; bus.cdb1Data_i = 32'hA;
    bus.cdb2En_i = 1'b1; bus.cdb2Id_i = 4'd9; bus.cdb2Data_i = 32'hB;
    wake_cyc("t4");
    chk("t4_a", 64'(bus.aluA_o), 64'hA);
    chk("t4_b", 64'(bus.aluB_o), 64'hB);
    idle(); cyc();
    disp(6'd11, 4'd7, 1'b1, 4'd1, 32'd0, 1'b1, 4'd1, 32'd0);
    cyc(); idle();
    bus.cdb1En_i = 1'b1; bus.cdb1Id_i = 4'd1; bus.cdb1Data_i = 32'h11;
    bus.cdb2En_i = 1'b1; bus.cdb2Id_i = 4'd1; bus.cdb2Data_i = 32'h22;
    wake_cyc("t4p");
    chk("t4p_a", 64'(bus.aluA_o), 64'h11);
    chk("t4p_b", 64'(bus.aluB_o), 64'h11);
    idle(); cyc();

    // T6: dispatch forwarding, then rdy low holds everything
    disp(6'd12, 4'd8, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd3);
    bus.cdb1En_i = 1'b1; bus.cdb1Id_i = 4'd6; bus.cdb1Data_i = 32'h77;
    cyc();
    idle(); cyc();
    chk("t6_en", 64'(bus.aluEn_o), 64'(1));
    chk("t6_a",  64'(bus.aluA_o),  64'h77);
    bus.rdy = 1'b0;
    disp(6'd13, 4'd9, 1'b0, 4'd0, 32'h99, 1'b0, 4'd0, 32'h98);
    repeat (3) begin
      cyc();
      chk("t6_hold_en", 64'(bus.aluEn_o), 64'(1));
      chk("t6_hold_a",  64'(bus.aluA_o),  64'h77);
    end
    idle(); cyc();
    chk("t6_drop", 64'(bus.aluEn_o), 64'(0));

    // T5: fill, overflow, flush
    for (int i = 0; i < 8; i++) begin
      disp(6'(i), 4'(i), 1'b1, 4'd15, 32'd0, 1'b0, 4'd0, 32'd0);
      cyc();
    end
    idle();
    chk("t5_full", 64'(bus.full_o), 64'(1));
    disp(6'd20, 4'd3, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
    cyc(); idle(); cyc();
    chk("t5_ovf", 64'(bus.aluEn_o), 64'(0));
    chk("t5_full2", 64'(bus.full_o), 64'(1));
    disp(6'd21, 4'd4, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
    bus.clear_i = 1'b1;
    cyc();
    chk("t5_clr_full", 64'(bus.full_o), 64'(0));
    chk("t5_clr_en",   64'(bus.aluEn_o), 64'(0));
    idle(); cyc();
    chk("t5_clr_drop", 64'(bus.aluEn_o), 64'(0));
    for (int i = 0; i < 3; i++) begin
      disp(6'(i), 4'(i), 1'b1, 4'd15, 32'd0, 1'b0, 4'd0, 32'd0);
      cyc();
    end
    disp(6'd22, 4'd5, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
    bus.clear_i = 1'b1; bus.rdy = 1'b0;
    cyc();
    idle();
    chk("t5_clrrdy_full", 64'(bus.full_o), 64'(0));
    cyc();
    chk("t5_clrrdy_drop", 64'(bus.aluEn_o), 64'(0));

    // T1: asynchronous reset with entries held and an issue in flight
    for (int i = 0; i < 3; i++) begin
      disp(6'(i), 4'(i), 1'b1, 4'd15, 32'd0, 1'b0, 4'd0, 32'd0);
      cyc();
    end
    disp(6'd30, 4'd12, 1'b0, 4'd0, 32'h31, 1'b0, 4'd0, 32'h32);
    cyc(); idle(); cyc();
    chk("t1_pre_en", 64'(bus.aluEn_o), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_en",   64'(bus.aluEn_o), 64'(0));
    chk("t1_full", 64'(bus.full_o),  64'(0));
    chk("t1_a",    64'(bus.aluA_o),  64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      cyc();
      chk("t1_stale", 64'(bus.aluEn_o), 64'(0));
    end

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      bus.rdy        = ($urandom_range(9) != 0);
      bus.clear_i    = ($urandom_range(59) == 0);
      bus.dispEn_i   = 1'($urandom_range(1));
      bus.dispOp_i   = 6'($urandom);
      bus.dispRobId_i = 4'($urandom);
      bus.dispVj_i   = $urandom;
      bus.dispQjEn_i = 1'($urandom_range(1));
      bus.dispQj_i   = 4'($urandom_range(7));
      bus.dispVk_i   = $urandom;
      bus.dispQkEn_i = 1'($urandom_range(1));
      bus.dispQk_i   = 4'($urandom_range(7));
      bus.dispImm_i  = $urandom;
      bus.dispPc_i   = $urandom;
      bus.cdb1En_i   = 1'($urandom_range(1));
      bus.cdb1Id_i   = 4'($urandom_range(7));
      bus.cdb1Data_i = $urandom;
      bus.cdb2En_i   = 1'($urandom_range(1));
      bus.cdb2Id_i   = 4'($urandom_range(7));
      bus.cdb2Data_i = $urandom;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
